// File: rtl/stream_rr_arbiter_if.sv
// Handshake bundle for stream_rr_arbiter: N upstream streams in, one merged stream out.
// A beat moves on a rising edge where valid=1 and ready=1; while valid=1 and ready=0 the
// sender keeps payload and last stable, and valid is never a function of ready.
interface stream_rr_arbiter_if #(
    parameter int  N_PORTS   = 4,
    parameter type DATA_TYPE = logic [31:0]
);
    DATA_TYPE           data_i [N_PORTS];
    logic [N_PORTS-1:0] last_i;
    logic [N_PORTS-1:0] valid_i;
    logic [N_PORTS-1:0] ready_o;
    DATA_TYPE           data_o;
    logic               last_o;
    logic               valid_o;
    logic               ready_i;
    logic [N_PORTS-1:0] grant_o;

    modport slave (
        input  data_i, last_i, valid_i, ready_i,
        output ready_o, data_o, last_o, valid_o, grant_o
    );

    modport master (
        output data_i, last_i, valid_i, ready_i,
        input  ready_o, data_o, last_o, valid_o, grant_o
    );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Packet-aware N-input round-robin stream arbiter; a source keeps the output until its last beat.
// Define STREAM_ARB_OUTREG_EN to place a 2-entry skid register on the output (latency 1).
module stream_rr_arbiter #(
    parameter int  N_PORTS   = 4,
    parameter type DATA_TYPE = logic [31:0]
) (
    input  logic               ACLK,
    input  logic               ARESET,
    stream_rr_arbiter_if.slave io_bus,
    output logic               o_dbg_state
);
    localparam int PTR_W = $clog2(N_PORTS);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic [PTR_W-1:0]   r_owner, w_owner_nxt;
    logic [PTR_W-1:0]   w_rr_sel;
    logic               w_rr_any;
    int                 w_idx;
    logic [PTR_W-1:0]   w_sel;
    logic               w_req;
    logic [N_PORTS-1:0] w_grant;
    logic               w_core_valid;
    logic               w_core_last;
    logic               w_core_ready;
    logic               w_hs;
    DATA_TYPE           w_core_data;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
        if (v == PTR_W'(N_PORTS - 1)) return '0;
        return v + PTR_W'(1);
    endfunction

    // First requester at or after r_ptr, wrapping past the highest port.
    always_comb begin : rr_search
        w_rr_any = 1'b0;
        w_rr_sel = r_ptr;
        w_idx    = 0;
        for (int i = 0; i < N_PORTS; i++) begin
            w_idx = (int'(r_ptr) + i) % N_PORTS;
            if (!w_rr_any && io_bus.valid_i[PTR_W'(w_idx)]) begin
                w_rr_any = 1'b1;
                w_rr_sel = PTR_W'(w_idx);
            end
        end
    end

    always_comb begin : select
        w_sel = w_rr_sel;
        w_req = w_rr_any;
        if (r_state == LOCKED) begin
            w_sel = r_owner;
            w_req = 1'b1;
        end
        if (ARESET) begin
            w_req = 1'b0;
        end
    end

    assign w_grant        = w_req ? (N_PORTS'(1) << w_sel) : '0;
    assign w_core_valid   = w_req && io_bus.valid_i[w_sel];
    assign w_core_data    = io_bus.data_i[w_sel];
    assign w_core_last    = io_bus.last_i[w_sel];
    assign w_hs           = w_core_valid && w_core_ready;
    assign io_bus.grant_o = w_grant;
    assign io_bus.ready_o = w_core_ready ? w_grant : '0;
    assign o_dbg_state    = r_state;

    // A stalled first beat still locks, so the chosen source cannot be displaced mid-stall.
    always_comb begin : fsm_next
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_hs && w_core_last) begin
                        w_ptr_nxt = wrap_inc(w_sel);
                    end else begin
                        w_state_nxt = LOCKED;
                        w_owner_nxt = w_sel;
                    end
                end
            end
            LOCKED: begin
                if (w_hs && w_core_last) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = wrap_inc(r_owner);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin : fsm_reg
        if (ARESET) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

`ifdef STREAM_ARB_OUTREG_EN
    DATA_TYPE   r_skid_data [2];
    logic [1:0] r_skid_last;
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_pop;

    // Core ready comes only from occupancy, which cuts the ready_i -> ready_o path.
    assign w_core_ready   = (r_count != 2'd2);
    assign w_pop          = (r_count != 2'd0) && io_bus.ready_i;
    assign io_bus.valid_o = (r_count != 2'd0);
    assign io_bus.data_o  = r_skid_data[r_rd_ptr];
    assign io_bus.last_o  = r_skid_last[r_rd_ptr];

    always_ff @(posedge ACLK) begin : skid_reg
        if (ARESET) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_hs) begin
                r_skid_data[r_wr_ptr] <= w_core_data;
                r_skid_last[r_wr_ptr] <= w_core_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_hs} - {1'b0, w_pop};
        end
    end
`else
    assign w_core_ready   = io_bus.ready_i;
    assign io_bus.valid_o = w_core_valid;
    assign io_bus.data_o  = w_core_data;
    assign io_bus.last_o  = w_core_last;
`endif
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed scenarios plus a randomized run checked against a
// packet-level reference model and per-port in-order scoreboard queues.
`timescale 1ns/1ps
module tb_stream_rr_arbiter;
    localparam int N               = 4;
    localparam int W               = 32;
    localparam int RAND_BEATS      = 1000;
    localparam int RAND_MAX_CYCLES = 20000;
    typedef logic [W-1:0] data_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dbg_state;
    int   n_vec = 0;
    int   n_err = 0;

    stream_rr_arbiter_if #(.N_PORTS(N), .DATA_TYPE(data_t)) bus ();

    stream_rr_arbiter #(.N_PORTS(N), .DATA_TYPE(data_t)) dut (
        .ACLK       (clk),
        .ARESET     (rst),
        .io_bus     (bus),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        for (int k = 0; k < N; k++) begin
            bus.valid_i[k] = 1'b0;
            bus.last_i[k]  = 1'b0;
            bus.data_i[k]  = '0;
        end
        bus.ready_i = 1'b0;
    endtask

    task automatic drive_port(input int k, input data_t d, input logic l);
        bus.valid_i[k] = 1'b1;
        bus.data_i[k]  = d;
        bus.last_i[k]  = l;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.ready_i = 1'b1;
        for (int k = 0; k < N; k++) drive_port(k, 32'h100 + k, 1'b1);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL reset valid_o c%0d: got %b want 0", c, bus.valid_o); end
            n_vec++;
            if (bus.grant_o !== 4'b0000) begin n_err++; $display("FAIL reset grant_o c%0d: got %b want 0000", c, bus.grant_o); end
            n_vec++;
            if (bus.ready_o !== 4'b0000) begin n_err++; $display("FAIL reset ready_o c%0d: got %b want 0000", c, bus.ready_o); end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (dbg_state !== 1'b0) begin n_err++; $display("FAIL reset state: got %b want IDLE(0)", dbg_state); end
        n_vec++;
        if (bus.grant_o !== 4'b0001) begin n_err++; $display("FAIL reset first grant: got %b want 0001", bus.grant_o); end
`ifndef STREAM_ARB_OUTREG_EN
        n_vec++;
        if (bus.data_o !== 32'h100) begin n_err++; $display("FAIL reset first data: got %h want 00000100", bus.data_o); end
`endif
        @(posedge clk);
        #1 drive_idle();
    endtask

`ifndef STREAM_ARB_OUTREG_EN
    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        apply_reset();
        @(negedge clk);
        bus.ready_i = 1'b1;
        for (int k = 0; k < N; k++) drive_port(k, data_t'(k), 1'b1);
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_g = '0;
            exp_g[i % N] = 1'b1;
            n_vec++;
            if (bus.data_o !== data_t'(i % N) || bus.valid_o !== 1'b1) begin
                n_err++; $display("FAIL rr data c%0d: got %0d/v%b want %0d/v1", i, bus.data_o, bus.valid_o, i % N);
            end
            n_vec++;
            if (bus.grant_o !== exp_g || bus.ready_o !== exp_g) begin
                n_err++; $display("FAIL rr grant c%0d: got g%b r%b want %b", i, bus.grant_o, bus.ready_o, exp_g);
            end
            @(negedge clk);
        end
        drive_idle();
    endtask

    task automatic test_packet_lock();
        apply_reset();
        @(negedge clk);
        bus.ready_i = 1'b1;
        drive_port(1, 32'hA1, 1'b0);
        #1;
        n_vec++;
        if (bus.data_o !== 32'hA1 || bus.grant_o !== 4'b0010) begin
            n_err++; $display("FAIL lock A1: got %h g%b want a1 g0010", bus.data_o, bus.grant_o);
        end
        @(negedge clk);
        drive_port(1, 32'hA2, 1'b0);
        drive_port(0, 32'hB0, 1'b1);
        #1;
        n_vec++;
        if (bus.data_o !== 32'hA2 || bus.ready_o !== 4'b0010) begin
            n_err++; $display("FAIL lock A2: got %h r%b want a2 r0010", bus.data_o, bus.ready_o);
        end
        @(negedge clk);
        drive_port(1, 32'hA3, 1'b1);
        #1;
        n_vec++;
        if (bus.data_o !== 32'hA3 || bus.last_o !== 1'b1 || bus.ready_o !== 4'b0010) begin
            n_err++; $display("FAIL lock A3: got %h l%b r%b want a3 l1 r0010", bus.data_o, bus.last_o, bus.ready_o);
        end
        @(negedge clk);
        bus.valid_i[1] = 1'b0;
        #1;
        n_vec++;
        if (bus.data_o !== 32'hB0 || bus.grant_o !== 4'b0001 || bus.ready_o !== 4'b0001) begin
            n_err++; $display("FAIL lock port0 after: got %h g%b r%b want b0 g0001 r0001", bus.data_o, bus.grant_o, bus.ready_o);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_backpressure();
        apply_reset();
        @(negedge clk);
        bus.ready_i = 1'b0;
        drive_port(2, 32'hCAFE, 1'b1);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) drive_port(0, 32'h0B0B, 1'b1);
            #1;
            n_vec++;
            if (bus.data_o !== 32'hCAFE || bus.valid_o !== 1'b1 || bus.grant_o !== 4'b0100 || bus.ready_o !== 4'b0000) begin
                n_err++; $display("FAIL bp stall c%0d: got %h v%b g%b r%b want cafe v1 g0100 r0000",
                                  c, bus.data_o, bus.valid_o, bus.grant_o, bus.ready_o);
            end
            @(negedge clk);
        end
        bus.ready_i = 1'b1;
        #1;
        n_vec++;
        if (bus.data_o !== 32'hCAFE || bus.ready_o !== 4'b0100) begin
            n_err++; $display("FAIL bp release: got %h r%b want cafe r0100", bus.data_o, bus.ready_o);
        end
        @(negedge clk);
        bus.valid_i[2] = 1'b0;
        #1;
        n_vec++;
        if (bus.data_o !== 32'h0B0B || bus.grant_o !== 4'b0001) begin
            n_err++; $display("FAIL bp next: got %h g%b want 0b0b g0001", bus.data_o, bus.grant_o);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        @(negedge clk);
        bus.ready_i = 1'b1;
        drive_port(3, 32'hD0, 1'b0);
        #1;
        n_vec++;
        if (bus.grant_o !== 4'b1000) begin n_err++; $display("FAIL midrst beat1 grant: got %b want 1000", bus.grant_o); end
        @(negedge clk);
        drive_port(3, 32'hD1, 1'b0);
        rst = 1'b1;
        #1;
        n_vec++;
        if (dbg_state !== 1'b1) begin n_err++; $display("FAIL midrst locked: got %b want LOCKED(1)", dbg_state); end
        n_vec++;
        if (bus.valid_o !== 1'b0 || bus.grant_o !== 4'b0000) begin
            n_err++; $display("FAIL midrst in reset: got v%b g%b want v0 g0000", bus.valid_o, bus.grant_o);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) drive_port(k, 32'hE0 + k, 1'b1);
        #1;
        n_vec++;
        if (dbg_state !== 1'b0) begin n_err++; $display("FAIL midrst state: got %b want IDLE(0)", dbg_state); end
        n_vec++;
        if (bus.grant_o !== 4'b0001 || bus.data_o !== 32'hE0) begin
            n_err++; $display("FAIL midrst regrant: got g%b %h want g0001 e0", bus.grant_o, bus.data_o);
        end
        @(negedge clk);
        drive_idle();
    endtask
`endif

    // Random traffic. Reference: a packet in progress keeps the output; otherwise the next
    // packet goes to the first requester after the previous winner in rotation order.
    task automatic test_random();
        logic [W:0]   exp_q [N][$];
        logic [W:0]   out_q [$];
        logic         src_valid [N];
        data_t        src_data [N];
        logic         src_last [N];
        int           src_seq [N];
        int           cur;
        int           last_win;
        int           sel;
        bit           any;
        logic         exp_cv;
        logic         core_ready;
        logic         hs;
        logic [N-1:0] exp_g;
        logic [N-1:0] exp_r;
        logic [W:0]   got_beat;
        int           port;
        int           out_open;
        int           beats_out;
        int           cyc;

        apply_reset();
        for (int k = 0; k < N; k++) begin
            src_valid[k] = 1'b0; src_data[k] = '0; src_last[k] = 1'b0; src_seq[k] = 0;
        end
        cur = -1; last_win = N - 1; out_open = -1; beats_out = 0; cyc = 0;

        while (beats_out < RAND_BEATS && cyc < RAND_MAX_CYCLES) begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < N; k++) begin
                if (!src_valid[k] && $urandom_range(0, 3) != 0) begin
                    src_valid[k] = 1'b1;
                    src_data[k]  = {8'(k), 24'(src_seq[k])};
                    src_last[k]  = ($urandom_range(0, 2) == 0);
                    src_seq[k]++;
                    exp_q[k].push_back({src_last[k], src_data[k]});
                end
                bus.valid_i[k] = src_valid[k];
                bus.data_i[k]  = src_data[k];
                bus.last_i[k]  = src_last[k];
            end
            bus.ready_i = ($urandom_range(0, 3) != 0);
            #1;

            any = 1'b0; sel = 0;
            if (cur >= 0) begin
                any = 1'b1; sel = cur;
            end else begin
                for (int i = 1; i <= N; i++) begin
                    if (!any && src_valid[(last_win + i) % N]) begin
                        any = 1'b1; sel = (last_win + i) % N;
                    end
                end
            end
            exp_g = '0;
            if (any) exp_g[sel] = 1'b1;
            exp_cv = any && src_valid[sel];
`ifdef STREAM_ARB_OUTREG_EN
            core_ready = (out_q.size() < 2);
`else
            core_ready = bus.ready_i;
`endif
            exp_r = core_ready ? exp_g : '0;

            n_vec++;
            if (bus.grant_o !== exp_g || bus.ready_o !== exp_r) begin
                n_err++; $display("FAIL rand grant cyc%0d: got g%b r%b want g%b r%b", cyc, bus.grant_o, bus.ready_o, exp_g, exp_r);
            end
`ifdef STREAM_ARB_OUTREG_EN
            n_vec++;
            if (bus.valid_o !== (out_q.size() > 0)) begin
                n_err++; $display("FAIL rand valid_o cyc%0d: got %b want %b", cyc, bus.valid_o, out_q.size() > 0);
            end else if (out_q.size() > 0) begin
                n_vec++;
                if ({bus.last_o, bus.data_o} !== out_q[0]) begin
                    n_err++; $display("FAIL rand skid beat cyc%0d: got %h want %h", cyc, {bus.last_o, bus.data_o}, out_q[0]);
                end
            end
`else
            n_vec++;
            if (bus.valid_o !== exp_cv) begin
                n_err++; $display("FAIL rand valid_o cyc%0d: got %b want %b", cyc, bus.valid_o, exp_cv);
            end else if (exp_cv) begin
                n_vec++;
                if ({bus.last_o, bus.data_o} !== {src_last[sel], src_data[sel]}) begin
                    n_err++; $display("FAIL rand beat cyc%0d: got %h want %h", cyc, {bus.last_o, bus.data_o}, {src_last[sel], src_data[sel]});
                end
            end
`endif

            if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
                got_beat = {bus.last_o, bus.data_o};
                port = int'(bus.data_o[31:24]);
                beats_out++;
                n_vec++;
                if (port >= N || exp_q[port].size() == 0) begin
                    n_err++; $display("FAIL sb unexpected beat cyc%0d: got %h want a queued beat", cyc, got_beat);
                end else begin
                    if (got_beat !== exp_q[port][0]) begin
                        n_err++; $display("FAIL sb order p%0d cyc%0d: got %h want %h", port, cyc, got_beat, exp_q[port][0]);
                    end
                    void'(exp_q[port].pop_front());
                    n_vec++;
                    if (out_open >= 0 && port != out_open) begin
                        n_err++; $display("FAIL sb interleave cyc%0d: got port %0d want port %0d", cyc, port, out_open);
                    end
                    out_open = bus.last_o ? -1 : port;
                end
            end

            hs = exp_cv && core_ready;
`ifdef STREAM_ARB_OUTREG_EN
            if (out_q.size() > 0 && bus.ready_i) void'(out_q.pop_front());
            if (hs) out_q.push_back({src_last[sel], src_data[sel]});
`endif
            if (any) begin
                if (hs && src_last[sel]) begin
                    cur = -1; last_win = sel;
                end else begin
                    cur = sel;
                end
            end
            if (hs) src_valid[sel] = 1'b0;
        end

        n_vec++;
        if (beats_out < RAND_BEATS) begin
            n_err++; $display("FAIL rand timeout: got %0d beats want %0d within %0d cycles", beats_out, RAND_BEATS, RAND_MAX_CYCLES);
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
`ifndef STREAM_ARB_OUTREG_EN
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_reset_mid_packet();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
